// File: rtl/ex_alu_muldiv.sv
// Execute-stage ALU with operand forwarding and an iterative multiply/divide unit.
// Single-cycle ops complete the next cycle; M-ops take one cycle per bit and stall via busy.
module ex_alu_muldiv #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [5:0]      alu_control,
  input  logic [XLEN-1:0] read_data1_in,
  input  logic [XLEN-1:0] read_data2_in,
  input  logic [XLEN-1:0] ex_mem_alu_result_in,
  input  logic [XLEN-1:0] mem_wb_result_in,
  input  logic [1:0]      forwardA,
  input  logic [1:0]      forwardB,
  input  logic [XLEN-1:0] imm_val_r,
  input  logic [SHW-1:0]  shamt,
  input  logic            alu_src,
  input  logic            flush,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN);

  localparam logic [5:0] OP_ADD   = 6'b000001;
  localparam logic [5:0] OP_SUB   = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b000011;
  localparam logic [5:0] OP_OR    = 6'b000100;
  localparam logic [5:0] OP_XOR   = 6'b000101;
  localparam logic [5:0] OP_SLL   = 6'b000110;
  localparam logic [5:0] OP_SRL   = 6'b000111;
  localparam logic [5:0] OP_SRA   = 6'b001000;
  localparam logic [5:0] OP_SLT   = 6'b001001;
  localparam logic [5:0] OP_SLTU  = 6'b001010;
  localparam logic [5:0] OP_ADDI  = 6'b001011;
  localparam logic [5:0] OP_BEQ   = 6'b011100;
  localparam logic [5:0] OP_BNE   = 6'b011101;
  localparam logic [5:0] OP_MUL   = 6'b100000;
  localparam logic [5:0] OP_MULH  = 6'b100001;
  localparam logic [5:0] OP_MULHU = 6'b100010;
  localparam logic [5:0] OP_DIV   = 6'b100100;
  localparam logic [5:0] OP_DIVU  = 6'b100101;
  localparam logic [5:0] OP_REM   = 6'b100110;
  localparam logic [5:0] OP_REMU  = 6'b100111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, m_q, m_d, a_q, a_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [5:0]        op_q, op_d;
  logic              neg_q, neg_d, neg_a_q, neg_a_d, bz_q, bz_d;
  logic              result_valid_q, result_valid_d, busy_q, busy_d;

  logic [XLEN-1:0]   op_a, op_b, op_b_fwd, alu_res, mag_a, mag_b, mop_res;
  logic [SHW-1:0]    sh_amt;
  logic              mop_mul, mop_div, mop_sgn, sa, sb;

  logic [XLEN:0]     mul_sum, div_rs, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   hi_n, lo_n, q_fix, r_fix;
  logic [2*XLEN-1:0] prod, prod_fix;

  // Forwarding muxes
  always_comb begin
    unique case (forwardA)
      2'b10:   op_a = ex_mem_alu_result_in;
      2'b01:   op_a = mem_wb_result_in;
      default: op_a = read_data1_in;
    endcase
    unique case (forwardB)
      2'b10:   op_b_fwd = ex_mem_alu_result_in;
      2'b01:   op_b_fwd = mem_wb_result_in;
      default: op_b_fwd = read_data2_in;
    endcase
    op_b = alu_src ? imm_val_r : op_b_fwd;
  end

  assign sh_amt = alu_src ? shamt : op_b[SHW-1:0];

  always_comb begin
    unique case (alu_control)
      OP_ADD, OP_ADDI: alu_res = op_a + op_b;
      OP_SUB:          alu_res = op_a - op_b;
      OP_AND:          alu_res = op_a & op_b;
      OP_OR:           alu_res = op_a | op_b;
      OP_XOR:          alu_res = op_a ^ op_b;
      OP_SLL:          alu_res = op_a << sh_amt;
      OP_SRL:          alu_res = op_a >> sh_amt;
      OP_SRA:          alu_res = $unsigned($signed(op_a) >>> sh_amt);
      OP_SLT:          alu_res = XLEN'($signed(op_a) < $signed(op_b));
      OP_SLTU:         alu_res = XLEN'(op_a < op_b);
      OP_BEQ:          alu_res = XLEN'(op_a == op_b);
      OP_BNE:          alu_res = XLEN'(op_a != op_b);
      default:         alu_res = '0;
    endcase
  end

  // M-op decode and operand magnitudes for the iterative unit
  always_comb begin
    mop_mul = 1'b0;
    mop_div = 1'b0;
    mop_sgn = 1'b0;
    case (alu_control)
      OP_MUL, OP_MULH:  begin mop_mul = 1'b1; mop_sgn = 1'b1; end
      OP_MULHU:         mop_mul = 1'b1;
      OP_DIV, OP_REM:   begin mop_div = 1'b1; mop_sgn = 1'b1; end
      OP_DIVU, OP_REMU: mop_div = 1'b1;
      default: ;
    endcase
    sa    = mop_sgn & op_a[XLEN-1];
    sb    = mop_sgn & op_b[XLEN-1];
    mag_a = sa ? -op_a : op_a;
    mag_b = sb ? -op_b : op_b;
  end

  // One shift-add or restoring-divide step, plus sign fix-up of the final step
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    div_rs   = {hi_q, lo_q[XLEN-1]};
    div_ge   = div_rs >= {1'b0, m_q};
    div_diff = div_rs - {1'b0, m_q};
    if (state_q == S_MUL) begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end else begin
      hi_n = div_ge ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], div_ge};
    end
    prod     = {hi_n, lo_n};
    prod_fix = neg_q ? -prod : prod;
    q_fix    = bz_q ? '1 : (neg_q ? -lo_n : lo_n);
    r_fix    = bz_q ? a_q : (neg_a_q ? -hi_n : hi_n);
    unique case (op_q)
      OP_MUL:            mop_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHU: mop_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:   mop_res = q_fix;
      OP_REM, OP_REMU:   mop_res = r_fix;
      default:           mop_res = '0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    hi_d           = hi_q;
    lo_d           = lo_q;
    m_d            = m_q;
    a_d            = a_q;
    op_d           = op_q;
    neg_d          = neg_q;
    neg_a_d        = neg_a_q;
    bz_d           = bz_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    busy_d         = busy_q;
    if (flush) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (mop_mul || mop_div) begin
              state_d = mop_mul ? S_MUL : S_DIV;
              busy_d  = 1'b1;
              cnt_d   = '0;
              op_d    = alu_control;
              a_d     = op_a;
              hi_d    = '0;
              lo_d    = mop_mul ? mag_b : mag_a;
              m_d     = mop_mul ? mag_a : mag_b;
              neg_d   = sa ^ sb;
              neg_a_d = sa;
              bz_d    = (op_b == '0);
            end else begin
              result_d       = alu_res;
              result_valid_d = 1'b1;
            end
          end
        end
        default: begin
          hi_d  = hi_n;
          lo_d  = lo_n;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN-1)) begin
            state_d        = S_IDLE;
            busy_d         = 1'b0;
            cnt_d          = '0;
            result_d       = mop_res;
            result_valid_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      hi_q           <= '0;
      lo_q           <= '0;
      m_q            <= '0;
      a_q            <= '0;
      op_q           <= '0;
      neg_q          <= 1'b0;
      neg_a_q        <= 1'b0;
      bz_q           <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      hi_q           <= hi_d;
      lo_q           <= lo_d;
      m_q            <= m_d;
      a_q            <= a_d;
      op_q           <= op_d;
      neg_q          <= neg_d;
      neg_a_q        <= neg_a_d;
      bz_q           <= bz_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_ex_alu_muldiv.sv
// Directed bench for ex_alu_muldiv (XLEN=32): ALU ops, forwarding, M-op timing, flush and reset.
module tb_ex_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [5:0]  alu_control;
  logic [31:0] read_data1_in, read_data2_in, ex_mem_alu_result_in, mem_wb_result_in;
  logic [1:0]  forwardA, forwardB;
  logic [31:0] imm_val_r;
  logic [4:0]  shamt;
  logic        alu_src, flush;
  logic [31:0] result;
  logic        result_valid, busy;

  int checks   = 0;
  int failures = 0;

  ex_alu_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_control(alu_control),
    .read_data1_in(read_data1_in), .read_data2_in(read_data2_in),
    .ex_mem_alu_result_in(ex_mem_alu_result_in), .mem_wb_result_in(mem_wb_result_in),
    .forwardA(forwardA), .forwardB(forwardB), .imm_val_r(imm_val_r), .shamt(shamt),
    .alu_src(alu_src), .flush(flush), .result(result), .result_valid(result_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] exm,
                        input logic [31:0] mwb, input logic [31:0] imm, input logic [4:0] sh,
                        input logic src);
    alu_control = op; read_data1_in = a; read_data2_in = b;
    forwardA = fa; forwardB = fb; ex_mem_alu_result_in = exm; mem_wb_result_in = mwb;
    imm_val_r = imm; shamt = sh; alu_src = src; in_valid = 1'b1;
  endtask

  // Single-cycle op: result_valid must be high exactly one cycle after acceptance
  task automatic alu_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] fa, input logic [1:0] fb,
                        input logic [31:0] exm, input logic [31:0] mwb, input logic [31:0] imm,
                        input logic [4:0] sh, input logic src, input logic [31:0] exp);
    @(negedge clk);
    set_in(op, a, b, fa, fb, exm, mwb, imm, sh, src);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_vld"}, 64'(result_valid), 64'd1);
    check(tag, 64'(result), 64'(exp));
    @(posedge clk); #1;
    check({tag, "_vld0"}, 64'(result_valid), 64'd0);
  endtask

  // M-op: busy for 32 cycles with no result_valid, then result with busy low
  task automatic mop(input string tag, input logic [5:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    int bad;
    @(negedge clk);
    set_in(op, a, b, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 5'h0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    bad = 0;
    for (int i = 1; i <= 32; i++) begin
      if (busy !== 1'b1 || result_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check({tag, "_busywin"}, 64'(bad), 64'd0);
    check({tag, "_busy0"}, 64'(busy), 64'd0);
    check({tag, "_vld"}, 64'(result_valid), 64'd1);
    check(tag, 64'(result), 64'(exp));
  endtask

  // Abort a DIV at cycle N+10 by flush (kind=0) or reset (kind=1); no pulse through N+40
  task automatic abort_div(input string tag, input bit use_rst);
    int pulses;
    @(negedge clk);
    set_in(6'b100101, 32'd100, 32'd7, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 5'h0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
    end
    if (use_rst) begin
      rst = 1'b1;
      #1;
      check({tag, "_busy_async"}, 64'(busy), 64'd0);
      check({tag, "_res_rst"}, 64'(result), 64'd0);
    end else begin
      flush = 1'b1;
    end
    @(posedge clk); #1;
    rst   = 1'b0;
    flush = 1'b0;
    check({tag, "_busy0"}, 64'(busy), 64'd0);
    pulses = 0;
    for (int i = 11; i <= 40; i++) begin
      if (result_valid !== 1'b0 || busy !== 1'b0) pulses++;
      @(posedge clk); #1;
    end
    check({tag, "_nopulse"}, 64'(pulses), 64'd0);
  endtask

  initial begin
    int bad;
    rst = 1'b1; flush = 1'b0;
    set_in(6'h0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 5'h0, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", 64'(result), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    //     tag      op         rd1           rd2           fA     fB     ex_mem        mem_wb        imm           sh  src exp
    alu_op("add_fw", 6'b000001, 32'h10,       32'h20,       2'b10, 2'b00, 32'h100,      32'h0,        32'h0,        0, 0, 32'h120);
    alu_op("add_f11",6'b000001, 32'h5,        32'h3,        2'b11, 2'b00, 32'h100,      32'h0,        32'h0,        0, 0, 32'h8);
    alu_op("sub_fb", 6'b000010, 32'h300,      32'h1,        2'b00, 2'b10, 32'h100,      32'h0,        32'h0,        0, 0, 32'h200);
    alu_op("sub_wr", 6'b000010, 32'h5,        32'h7,        2'b00, 2'b00, 32'h0,        32'h0,        32'h0,        0, 0, 32'hFFFFFFFE);
    alu_op("and",    6'b000011, 32'hF0F0,     32'hFF00,     2'b00, 2'b00, 32'h0,        32'h0,        32'h0,        0, 0, 32'hF000);
    alu_op("or",     6'b000100, 32'hF0F0,     32'hFF00,     2'b00, 2'b00, 32'h0,        32'h0,        32'h0,        0, 0, 32'hFFF0);
    alu_op("xor",    6'b000101, 32'hF0F0,     32'hFF00,     2'b00, 2'b00, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0FF0);
    alu_op("sll_im", 6'b000110, 32'h1,        32'h1F,       2'b00, 2'b00, 32'h0,        32'h0,        32'h0,        4, 1, 32'h10);
    alu_op("srl",    6'b000111, 32'h80000000, 32'h24,       2'b00, 2'b00, 32'h0,        32'h0,        32'h0,        0, 0, 32'h08000000);
    alu_op("sra",    6'b001000, 32'h80000000, 32'h24,       2'b00, 2'b00, 32'h0,        32'h0,        32'h0,        0, 0, 32'hF8000000);
    alu_op("slt",    6'b001001, 32'hFFFFFFFF, 32'h1,        2'b00, 2'b00, 32'h0,        32'h0,        32'h0,        0, 0, 32'h1);
    alu_op("sltu",   6'b001010, 32'hFFFFFFFF, 32'h1,        2'b00, 2'b00, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0);
    alu_op("addi",   6'b001011, 32'd100,      32'h55,       2'b00, 2'b10, 32'h999,      32'h0,        32'hFFFFFFFF, 0, 1, 32'd99);
    alu_op("beq_eq", 6'b011100, 32'h1,        32'h2,        2'b10, 2'b10, 32'h100,      32'h0,        32'h0,        0, 0, 32'h1);
    alu_op("beq_ne", 6'b011100, 32'h1,        32'h2,        2'b10, 2'b01, 32'h100,      32'h200,      32'h0,        0, 0, 32'h0);
    alu_op("bne",    6'b011101, 32'h1,        32'h2,        2'b00, 2'b00, 32'h0,        32'h0,        32'h0,        0, 0, 32'h1);
    alu_op("badop",  6'b111111, 32'h1,        32'h2,        2'b00, 2'b00, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0);

    mop("mulh",  6'b100001, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF);
    mop("mulhu", 6'b100010, 32'hFFFFFFFF, 32'h2,        32'h1);
    mop("mul",   6'b100000, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE);
    mop("div_ov",6'b100100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    mop("rem_ov",6'b100110, 32'h80000000, 32'hFFFFFFFF, 32'h0);
    mop("divu_z",6'b100101, 32'h1234,     32'h0,        32'hFFFFFFFF);
    mop("remu_z",6'b100111, 32'h7,        32'h0,        32'h7);
    mop("div_n", 6'b100100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD);
    mop("rem_n", 6'b100110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF);
    mop("divu",  6'b100101, 32'd100,      32'd7,        32'd14);
    mop("remu",  6'b100111, 32'd100,      32'd7,        32'd2);

    // Inputs change and in_valid stays high while busy; the held ADD goes in at completion
    @(negedge clk);
    set_in(6'b100101, 32'd100, 32'd7, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 5'h0, 1'b0);
    @(posedge clk); #1;
    set_in(6'b000001, 32'h50, 32'h3, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 5'h0, 1'b0);
    bad = 0;
    for (int i = 1; i <= 32; i++) begin
      if (busy !== 1'b1 || result_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check("hold_busywin", 64'(bad), 64'd0);
    check("hold_vld", 64'(result_valid), 64'd1);
    check("hold_div", 64'(result), 64'd14);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("hold_add_vld", 64'(result_valid), 64'd1);
    check("hold_add", 64'(result), 64'h53);

    abort_div("flush", 1'b0);
    abort_div("reset", 1'b1);

    // An op presented together with flush is not accepted
    @(negedge clk);
    set_in(6'b000001, 32'h1, 32'h1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 5'h0, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    check("flush_noacc", 64'(result_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
